// File: rtl/interrupt_controller_if.sv
// Bus between the interrupt controller, the keyboard receiver and the processor.
// The processor/keyboard side uses the master modport; the controller uses slave.
interface interrupt_controller_if;
    logic [7:0] KBD_DATA;
    logic       KBD_STROBE;
    logic [1:0] INT_IRQ;
    logic       INT_IACK;
    logic       INT_IEND;
    logic [7:0] KBD_KEY;
    logic       FRAME_OVERRUN;
    logic       KBD_OVERFLOW;

    modport master (
        output KBD_DATA, KBD_STROBE, INT_IACK, INT_IEND,
        input  INT_IRQ, KBD_KEY, FRAME_OVERRUN, KBD_OVERFLOW
    );

    modport slave (
        input  KBD_DATA, KBD_STROBE, INT_IACK, INT_IEND,
        output INT_IRQ, KBD_KEY, FRAME_OVERRUN, KBD_OVERFLOW
    );
endinterface

// File: rtl/interrupt_controller.sv
// Two-source interrupt controller: periodic frame tick plus a 4-deep keyboard FIFO,
// presented one request at a time with an IACK/IEND service handshake.
//
// state        | meaning
// IDLE         | no request shown; picks frame first, then key
// ASSERT_FRAME | frame request shown (INT_IRQ=00) until IACK
// ASSERT_KEY   | key request shown (INT_IRQ=01) until IACK, FIFO head on KBD_KEY
// SERVICE      | processor busy with the acknowledged request until IEND
module interrupt_controller #(
    parameter int unsigned FRAME_DIV = 833333
) (
    input  logic                         CLK,
    input  logic                         RESET,
    interrupt_controller_if.slave        bus
);

    typedef enum logic [1:0] {IDLE, ASSERT_FRAME, ASSERT_KEY, SERVICE} state_t;

    localparam logic [19:0] TIMER_LAST = 20'(FRAME_DIV - 1);

    state_t      state_q, state_d;
    logic [19:0] timer_q, timer_d;
    logic        frame_pend_q, frame_pend_d;
    logic        frame_ovr_q, frame_ovr_d;
    logic        kbd_ovf_q, kbd_ovf_d;
    logic [7:0]  fifo_mem_q [4];
    logic [7:0]  fifo_mem_d [4];
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]  count_q, count_d;

    logic        wrap;
    logic        ack_frame;
    logic        pop;
    logic        push;
    logic        full;
    logic [1:0]  irq;

    always_comb begin
        state_d   = state_q;
        ack_frame = 1'b0;
        pop       = 1'b0;
        irq       = 2'b11;
        case (state_q)
            IDLE: begin
                if (frame_pend_q)        state_d = ASSERT_FRAME;
                else if (count_q != 3'd0) state_d = ASSERT_KEY;
            end
            ASSERT_FRAME: begin
                irq = 2'b00;
                if (bus.INT_IACK) begin
                    ack_frame = 1'b1;
                    state_d   = SERVICE;
                end
            end
            ASSERT_KEY: begin
                irq = 2'b01;
                if (bus.INT_IACK) begin
                    pop     = 1'b1;
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (bus.INT_IEND) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A tick landing on the acknowledge edge starts a fresh request rather than an overrun.
    always_comb begin
        wrap         = (timer_q == TIMER_LAST);
        timer_d      = wrap ? 20'd0 : timer_q + 20'd1;
        frame_pend_d = (frame_pend_q & ~ack_frame) | wrap;
        frame_ovr_d  = frame_ovr_q | (wrap & frame_pend_q & ~ack_frame);
    end

    // When full, a same-cycle pop frees the head slot so the incoming key still fits.
    always_comb begin
        full       = (count_q == 3'd4);
        push       = bus.KBD_STROBE & (~full | pop);
        kbd_ovf_d  = kbd_ovf_q | (bus.KBD_STROBE & full & ~pop);
        fifo_mem_d = fifo_mem_q;
        if (push) fifo_mem_d[wr_ptr_q] = bus.KBD_DATA;
        wr_ptr_d   = wr_ptr_q + {1'b0, push};
        rd_ptr_d   = rd_ptr_q + {1'b0, pop};
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= IDLE;
            timer_q      <= 20'd0;
            frame_pend_q <= 1'b0;
            frame_ovr_q  <= 1'b0;
            kbd_ovf_q    <= 1'b0;
            rd_ptr_q     <= 2'd0;
            wr_ptr_q     <= 2'd0;
            count_q      <= 3'd0;
            for (int i = 0; i < 4; i++) fifo_mem_q[i] <= 8'h00;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            frame_pend_q <= frame_pend_d;
            frame_ovr_q  <= frame_ovr_d;
            kbd_ovf_q    <= kbd_ovf_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            fifo_mem_q   <= fifo_mem_d;
        end
    end

    assign bus.INT_IRQ       = irq;
    assign bus.KBD_KEY       = (count_q != 3'd0) ? fifo_mem_q[rd_ptr_q] : 8'h00;
    assign bus.FRAME_OVERRUN = frame_ovr_q;
    assign bus.KBD_OVERFLOW  = kbd_ovf_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios plus random traffic checked
// against a request-level model (tick schedule, key queue, shown request, busy flag).
module tb_interrupt_controller;

    localparam int FD = 16;

    logic CLK;
    logic RESET;
    int   checks;
    int   errors;

    interrupt_controller_if bus ();

    interrupt_controller #(.FRAME_DIV(FD)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Model: m_show 0 = nothing shown, 1 = frame shown, 2 = key shown.
    int         m_cyc;
    bit         m_pend, m_ovr, m_kovf, m_busy;
    int         m_show;
    logic [7:0] m_q [$];

    task automatic model_reset();
        m_cyc = 0; m_pend = 0; m_ovr = 0; m_kovf = 0; m_busy = 0; m_show = 0;
        m_q.delete();
    endtask

    task automatic model_step(input logic stb, input logic [7:0] d, input logic ack, input logic iend);
        bit tick, pend_old, clr;
        int nq_old;
        logic [7:0] dropped;
        m_cyc++;
        tick     = (m_cyc % FD) == 0;
        pend_old = m_pend;
        nq_old   = m_q.size();
        clr      = 0;
        if (m_show == 0 && !m_busy) begin
            if (pend_old) m_show = 1;
            else if (nq_old > 0) m_show = 2;
        end else if (m_show != 0) begin
            if (ack) begin
                clr = (m_show == 1);
                if (m_show == 2) dropped = m_q.pop_front();
                m_show = 0;
                m_busy = 1;
            end
        end else if (iend) begin
            m_busy = 0;
        end
        if (stb) begin
            if (m_q.size() < 4) m_q.push_back(d);
            else m_kovf = 1;
        end
        if (tick && pend_old && !clr) m_ovr = 1;
        m_pend = (pend_old && !clr) || tick;
    endtask

    function automatic logic [1:0] exp_irq();
        return (m_show == 1) ? 2'b00 : (m_show == 2) ? 2'b01 : 2'b11;
    endfunction

    function automatic logic [7:0] exp_key();
        return (m_q.size() > 0) ? m_q[0] : 8'h00;
    endfunction

    // Called at a falling edge; returns at the next falling edge with inputs idle.
    task automatic cycle(input logic stb, input logic [7:0] d, input logic ack, input logic iend);
        bus.KBD_STROBE = stb;
        bus.KBD_DATA   = d;
        bus.INT_IACK   = ack;
        bus.INT_IEND   = iend;
        model_step(stb, d, ack, iend);
        @(posedge CLK);
        @(negedge CLK);
        bus.KBD_STROBE = 1'b0;
        bus.KBD_DATA   = 8'h00;
        bus.INT_IACK   = 1'b0;
        bus.INT_IEND   = 1'b0;
    endtask

    task automatic assert_reset();
        RESET = 1'b0;
        model_reset();
        #2;
    endtask

    task automatic release_reset();
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        assert_reset();
        checks++; if (bus.INT_IRQ !== 2'b11) begin errors++; $display("FAIL reset_irq got=%b exp=11", bus.INT_IRQ); end
        checks++; if (bus.KBD_KEY !== 8'h00) begin errors++; $display("FAIL reset_key got=%h exp=00", bus.KBD_KEY); end
        checks++; if (bus.FRAME_OVERRUN !== 1'b0) begin errors++; $display("FAIL reset_ovr got=%b exp=0", bus.FRAME_OVERRUN); end
        checks++; if (bus.KBD_OVERFLOW !== 1'b0) begin errors++; $display("FAIL reset_kovf got=%b exp=0", bus.KBD_OVERFLOW); end
        release_reset();
    endtask

    task automatic test_frame();
        logic [1:0] want;
        assert_reset(); release_reset();
        for (int i = 1; i <= 17; i++) begin
            cycle(0, 8'h00, 0, 0);
            want = (i == 17) ? 2'b00 : 2'b11;
            checks++; if (bus.INT_IRQ !== want) begin errors++; $display("FAIL frame_first cyc=%0d got=%b exp=%b", i, bus.INT_IRQ, want); end
        end
        cycle(0, 8'h00, 1, 0);
        checks++; if (bus.INT_IRQ !== 2'b11) begin errors++; $display("FAIL frame_after_iack got=%b exp=11", bus.INT_IRQ); end
        cycle(0, 8'h00, 0, 1);
        for (int i = 20; i <= 33; i++) begin
            cycle(0, 8'h00, 0, 0);
            want = (i == 33) ? 2'b00 : 2'b11;
            checks++; if (bus.INT_IRQ !== want) begin errors++; $display("FAIL frame_second cyc=%0d got=%b exp=%b", i, bus.INT_IRQ, want); end
        end
    endtask

    task automatic test_key();
        assert_reset(); release_reset();
        cycle(1, 8'h20, 0, 0);
        checks++; if (bus.INT_IRQ !== 2'b11) begin errors++; $display("FAIL key_latency got=%b exp=11", bus.INT_IRQ); end
        cycle(0, 8'h00, 0, 0);
        checks++; if (bus.INT_IRQ !== 2'b01) begin errors++; $display("FAIL key_irq got=%b exp=01", bus.INT_IRQ); end
        checks++; if (bus.KBD_KEY !== 8'h20) begin errors++; $display("FAIL key_head got=%h exp=20", bus.KBD_KEY); end
        cycle(0, 8'h00, 1, 0);
        checks++; if (bus.KBD_KEY !== 8'h00) begin errors++; $display("FAIL key_after_iack got=%h exp=00", bus.KBD_KEY); end
        checks++; if (bus.INT_IRQ !== 2'b11) begin errors++; $display("FAIL key_irq_after_iack got=%b exp=11", bus.INT_IRQ); end
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 0, 1);
        cycle(0, 8'h00, 0, 0);
        checks++; if (bus.INT_IRQ !== 2'b11) begin errors++; $display("FAIL key_idle_after_iend got=%b exp=11", bus.INT_IRQ); end
    endtask

    task automatic test_priority();
        assert_reset(); release_reset();
        for (int i = 1; i <= 15; i++) cycle(0, 8'h00, 0, 0);
        cycle(1, 8'h33, 0, 0);
        cycle(0, 8'h00, 0, 0);
        checks++; if (bus.INT_IRQ !== 2'b00) begin errors++; $display("FAIL prio_frame_first got=%b exp=00", bus.INT_IRQ); end
        cycle(0, 8'h00, 1, 1);
        checks++; if (bus.INT_IRQ !== 2'b11) begin errors++; $display("FAIL prio_iack_iend got=%b exp=11", bus.INT_IRQ); end
        cycle(0, 8'h00, 0, 1);
        cycle(0, 8'h00, 0, 0);
        checks++; if (bus.INT_IRQ !== 2'b01) begin errors++; $display("FAIL prio_key_second got=%b exp=01", bus.INT_IRQ); end
        checks++; if (bus.KBD_KEY !== 8'h33) begin errors++; $display("FAIL prio_key_value got=%h exp=33", bus.KBD_KEY); end
    endtask

    task automatic test_overflow();
        logic [7:0] got [$];
        assert_reset(); release_reset();
        for (int i = 0; i < 5; i++) cycle(1, 8'(8'h11 + i), 0, 0);
        checks++; if (bus.KBD_OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", bus.KBD_OVERFLOW); end
        for (int c = 0; c < 80 && got.size() < 4; c++) begin
            if (bus.INT_IRQ == 2'b01) begin
                got.push_back(bus.KBD_KEY);
                cycle(0, 8'h00, 1, 0);
                cycle(0, 8'h00, 0, 1);
            end else if (bus.INT_IRQ == 2'b00) begin
                cycle(0, 8'h00, 1, 0);
                cycle(0, 8'h00, 0, 1);
            end else begin
                cycle(0, 8'h00, 0, 0);
            end
        end
        checks++; if (got.size() != 4) begin errors++; $display("FAIL ovf_served_count got=%0d exp=4", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            checks++; if (got[i] !== 8'(8'h11 + i)) begin errors++; $display("FAIL ovf_order idx=%0d got=%h exp=%h", i, got[i], 8'(8'h11 + i)); end
        end
        checks++; if (bus.KBD_KEY !== 8'h00) begin errors++; $display("FAIL ovf_empty got=%h exp=00", bus.KBD_KEY); end
        checks++; if (bus.KBD_OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", bus.KBD_OVERFLOW); end
    endtask

    task automatic test_overrun();
        int shown;
        assert_reset(); release_reset();
        for (int i = 1; i <= 33; i++) begin
            cycle(0, 8'h00, 0, 0);
            if (i == 31) begin
                checks++; if (bus.FRAME_OVERRUN !== 1'b0) begin errors++; $display("FAIL ovr_early got=%b exp=0", bus.FRAME_OVERRUN); end
            end
            if (i == 32) begin
                checks++; if (bus.FRAME_OVERRUN !== 1'b1) begin errors++; $display("FAIL ovr_set got=%b exp=1", bus.FRAME_OVERRUN); end
            end
        end
        checks++; if (bus.INT_IRQ !== 2'b00) begin errors++; $display("FAIL ovr_irq got=%b exp=00", bus.INT_IRQ); end
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 0, 1);
        shown = 0;
        for (int i = 36; i <= 48; i++) begin
            cycle(0, 8'h00, 0, 0);
            if (bus.INT_IRQ != 2'b11) shown++;
        end
        checks++; if (shown != 0) begin errors++; $display("FAIL ovr_single_serve got=%0d exp=0", shown); end
        checks++; if (bus.FRAME_OVERRUN !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%b exp=1", bus.FRAME_OVERRUN); end
    endtask

    task automatic test_reset_mid_service();
        int bad;
        assert_reset(); release_reset();
        cycle(1, 8'hA1, 0, 0);
        cycle(1, 8'hA2, 0, 0);
        cycle(1, 8'hA3, 0, 0);
        cycle(0, 8'h00, 1, 0);
        checks++; if (bus.KBD_KEY !== 8'hA2) begin errors++; $display("FAIL rst_pre_key got=%h exp=a2", bus.KBD_KEY); end
        assert_reset();
        checks++; if (bus.INT_IRQ !== 2'b11) begin errors++; $display("FAIL rst_mid_irq got=%b exp=11", bus.INT_IRQ); end
        checks++; if (bus.KBD_KEY !== 8'h00) begin errors++; $display("FAIL rst_mid_key got=%h exp=00", bus.KBD_KEY); end
        release_reset();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 8'h00, 0, 1);
            if (bus.INT_IRQ !== 2'b11 || bus.KBD_KEY !== 8'h00) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rst_no_key_after got=%0d exp=0", bad); end
    endtask

    task automatic test_random();
        logic       stb, ack, iend;
        logic [7:0] d;
        assert_reset(); release_reset();
        for (int i = 0; i < 800; i++) begin
            stb  = ($urandom_range(0, 2) == 0);
            d    = 8'($urandom);
            ack  = ($urandom_range(0, 3) == 0);
            iend = ($urandom_range(0, 2) == 0);
            cycle(stb, d, ack, iend);
            checks++; if (bus.INT_IRQ !== exp_irq()) begin errors++; $display("FAIL rand_irq cyc=%0d got=%b exp=%b", i, bus.INT_IRQ, exp_irq()); end
            checks++; if (bus.KBD_KEY !== exp_key()) begin errors++; $display("FAIL rand_key cyc=%0d got=%h exp=%h", i, bus.KBD_KEY, exp_key()); end
            checks++; if (bus.FRAME_OVERRUN !== m_ovr) begin errors++; $display("FAIL rand_ovr cyc=%0d got=%b exp=%b", i, bus.FRAME_OVERRUN, m_ovr); end
            checks++; if (bus.KBD_OVERFLOW !== m_kovf) begin errors++; $display("FAIL rand_kovf cyc=%0d got=%b exp=%b", i, bus.KBD_OVERFLOW, m_kovf); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RESET          = 1'b0;
        bus.KBD_STROBE = 1'b0;
        bus.KBD_DATA   = 8'h00;
        bus.INT_IACK   = 1'b0;
        bus.INT_IEND   = 1'b0;
        model_reset();
        @(negedge CLK);
        test_reset();
        test_frame();
        test_key();
        test_priority();
        test_overflow();
        test_overrun();
        test_reset_mid_service();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter FRAME_DIV, default 833333: clock cycles per frame tick (60 Hz at 50 MHz); legal range 16..2^20-1.
REQ-002 CLK  input  1: single clock; all state changes on rising edge.
REQ-003 RESET  input  1: asynchronous, active-low reset.
REQ-004 KBD_DATA  input  8: scancode from keyboard receiver, valid only while KBD_STROBE=1.
REQ-005 KBD_STROBE  input  1: one-cycle push request for KBD_DATA.
REQ-006 INT_IRQ  output  2: request code; 2'b00 frame, 2'b01 key, 2'b11 none; 2'b10 never driven.
REQ-007 INT_IACK  input  1: processor acknowledge, one-cycle pulse.
REQ-008 INT_IEND  input  1: processor end-of-service, one-cycle pulse.
REQ-009 KBD_KEY  output  8: head of key FIFO; 8'h00 when FIFO empty.
REQ-010 FRAME_OVERRUN  output  1: sticky; a frame tick arrived while a frame request was already pending.
REQ-011 KBD_OVERFLOW  output  1: sticky; a key was dropped because the FIFO was full.

Function
REQ-012 Frame timer: 20-bit counter counts 0..FRAME_DIV-1 and wraps; wrap cycle sets framePending.
REQ-013 A wrap while framePending=1 leaves framePending=1 and sets FRAME_OVERRUN; ticks never accumulate.
REQ-014 Key FIFO: 4 entries x 8 bits, with 3-bit count, 2-bit read and 2-bit write pointers; pointers wrap 3->0.
REQ-015 KBD_STROBE with count<4 pushes KBD_DATA; with count=4 the data is dropped and KBD_OVERFLOW is set.
REQ-016 A push and a pop in the same cycle both take effect; count unchanged; legal when full (pop frees the slot first) and when empty is impossible (no pop without a pending key).
REQ-017 KBD_KEY is combinational from FIFO head; it holds the key being serviced through the IACK cycle.
REQ-018 FSM states: IDLE, ASSERT_FRAME, ASSERT_KEY, SERVICE.
REQ-019 IDLE: INT_IRQ=2'b11; if framePending -> ASSERT_FRAME; else if count>0 -> ASSERT_KEY; else stay. Frame has priority.
REQ-020 ASSERT_FRAME: INT_IRQ=2'b00, held stable until INT_IACK; on INT_IACK clear framePending (same edge) -> SERVICE.
REQ-021 ASSERT_KEY: INT_IRQ=2'b01, held stable until INT_IACK; on INT_IACK pop FIFO at that edge -> SERVICE.
REQ-022 A frame tick arriving during ASSERT_KEY does not change INT_IRQ; it is served after the current key.
REQ-023 SERVICE: INT_IRQ=2'b11; stay until INT_IEND, then -> IDLE. Next request appears no earlier than 1 cycle after IEND.
REQ-024 IACK in IDLE or SERVICE, IEND outside SERVICE: ignored, no state or FIFO change.
REQ-025 IACK and IEND in the same cycle in an ASSERT state: IACK action taken, IEND ignored, -> SERVICE.
REQ-026 Latency: pending source to INT_IRQ valid = 1 cycle from IDLE (registered state, INT_IRQ decoded from state).
REQ-027 Frame timer and FIFO push keep running in every FSM state.

Reset
REQ-028 RESET=0 asynchronously forces: state IDLE, timer 0, framePending 0, FIFO empty (pointers and count 0), FRAME_OVERRUN 0, KBD_OVERFLOW 0.
REQ-029 During reset: INT_IRQ=2'b11, KBD_KEY=8'h00; reset asserted mid-service discards the in-flight request and all queued keys.
REQ-030 Sticky flags clear only by reset.

Verification
REQ-031 FRAME_DIV=16, no keys: INT_IRQ=2'b00 one cycle after the first wrap (cycle 17 after reset release); IACK -> 2'b11; IEND -> 2'b11 until next wrap.
REQ-032 Push 8'h20 -> INT_IRQ=2'b01, KBD_KEY=8'h20 through IACK cycle; after IACK, KBD_KEY=8'h00.
REQ-033 Key pending and frame wrap in same cycle from IDLE: frame served first (2'b00), then 2'b01 after IEND.
REQ-034 Push 5 keys 8'h11..8'h15 without IACK: KBD_OVERFLOW=1, keys served 8'h11..8'h14 in order, 8'h15 lost.
REQ-035 No IACK across two frame wraps: FRAME_OVERRUN=1; only one frame request served.
REQ-036 RESET=0 pulse while in SERVICE with 2 queued keys: INT_IRQ=2'b11, KBD_KEY=8'h00 immediately; no key request after release.
